// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit common-anode FND driver: active-low segment
// patterns for 0..9 and the "everything off" values for commons and font.
package fnd_pkg;

  // Segment order is {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7f;

  localparam logic [3:0] COMM_OFF = 4'hf;
  localparam logic [7:0] FONT_OFF = 8'hff;

endpackage

// File: rtl/bcd_to_fnd.sv
// Combinational BCD nibble to active-low 7-segment pattern; non-decimal codes
// (10..15) produce a dark digit rather than a hex glyph.
module bcd_to_fnd
  import fnd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit FND scanner: slot divider, digit index, once-per-frame input snapshot,
// anti-ghosting guard window, optional leading-zero blanking, registered outputs.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int SCAN_HZ      = 1_000,
  parameter int GUARD_CYCLES = 16,
  parameter bit LZB          = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dot_in,
  output logic [3:0]  fnd_comm,
  output logic [7:0]  fnd_font,
  output logic        frame_tick
);

  localparam int DIV   = CLK_FREQ / SCAN_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GUARD = CNT_W'(GUARD_CYCLES);

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow_bcd;
  logic [3:0]       shadow_dot;

  logic       tick;
  logic       guard;
  logic       blank;
  logic [3:0] digit;
  logic [6:0] seg;

  // A digit at position pos is a leading zero when it and every digit to its left are zero.
  function automatic logic lz_blank(input logic [15:0] bcd, input logic [1:0] pos);
    logic zero_above;
    zero_above = 1'b1;
    for (int k = 1; k < 4; k++)
      if (k >= int'(pos) && bcd[k*4 +: 4] != 4'h0) zero_above = 1'b0;
    return (pos != 2'd0) && zero_above;
  endfunction

  assign tick  = (div_cnt == LAST);
  assign guard = (div_cnt < GUARD);
  assign digit = shadow_bcd[{idx, 2'b00} +: 4];
  assign blank = LZB && lz_blank(shadow_bcd, idx);

  bcd_to_fnd u_dec (
    .bcd (digit),
    .seg (seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      idx        <= 2'd0;
      shadow_bcd <= 16'h0000;
      shadow_dot <= 4'hf;
      fnd_comm   <= COMM_OFF;
      fnd_font   <= FONT_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (tick) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
        // Snapshot only at the frame boundary so a refresh never mixes two time values.
        if (idx == 2'd3) begin
          shadow_bcd <= bcd_in;
          shadow_dot <= dot_in;
          frame_tick <= 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      // Output stage: one clock behind div_cnt/idx.
      if (guard) begin
        fnd_comm <= COMM_OFF;
        fnd_font <= FONT_OFF;
      end else begin
        fnd_comm <= ~(4'b0001 << idx);
        fnd_font <= {shadow_dot[idx], blank ? SEG_BLANK : seg};
      end
    end
  end

endmodule
